tap_bank_interleave: RTL and testbench
======================================

Name: tap_bank_interleave

Overview:
Parametrised multi-bank tap memory for the neural datapath. It holds NUM_BANKS independent DATA_W-wide banks of 2^ADDR_W words, read as one wide word. It supports broadcast wide writes, single-bank sub-writes, and an interleaved (rotating) read-address mode for tap reuse. This generation adds generic bank count and width, registered read-valid tracking, read-during-write bypass, address-counter wrap and illegal-sub-write flagging.

Parameters:
NUM_BANKS, 6, number of banks (≥2)
DATA_W, 32, width of one bank word
ADDR_W, 5, bank address width; depth = 2^ADDR_W
SEL_W, $clog2(NUM_BANKS), width of sub_bank

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
rd_vld  in  1  read request this cycle
rd_addr  in  ADDR_W  linear read address (non-interleaved mode)
inter  in  1  interleave step; advances rotation counters
inter_first  in  1  restart interleave sequence (qualified by inter)
wr_vld  in  1  broadcast write to all banks
wr_addr  in  ADDR_W  write address (all write types)
wr_data  in  NUM_BANKS*DATA_W  broadcast data; bank k at [k*DATA_W +: DATA_W]
sub_vld  in  1  single-bank write
sub_bank  in  SEL_W  target bank of sub-write
sub_data  in  DATA_W  sub-write data
rd_data  out  NUM_BANKS*DATA_W  read data, bank k in slice k
rd_data_vld  out  1  rd_data valid
sub_err  out  1  pulse: sub_vld with sub_bank ≥ NUM_BANKS

Behaviour:
- Reset: cnt_lo=0, cnt_hi=0, rd_data=0, rd_data_vld=0, sub_err=0. Bank contents are not cleared.
- cnt_lo (0..NUM_BANKS-1): on inter&inter_first → 0. On inter&cnt_lo==NUM_BANKS-1 → 0. Otherwise on inter → +1. Holds when inter=0.
- cnt_hi (ADDR_W bits): on inter&inter_first → 0. On inter&~inter_first&cnt_lo==NUM_BANKS-1 → cnt_hi+NUM_BANKS, mod 2^ADDR_W (wraps silently). Holds otherwise.
- Bank k read address:
  - when inter&~inter_first: ((cnt_lo+k) mod NUM_BANKS) + cnt_hi, truncated to ADDR_W. The mod is a single conditional subtract, valid because cnt_lo+k < 2*NUM_BANKS.
  - otherwise: rd_addr.
  - Counters are used pre-update (current-cycle values).
- Read latency 1: rd_vld in cycle t → rd_data and rd_data_vld=1 in t+1. With rd_vld=0, rd_data_vld=0 and rd_data holds its last value.
- Writes: bank k is written when (sub_vld & sub_bank==k) | (wr_vld & ~sub_vld).
  - Sub-write data is sub_data; broadcast data is slice k of wr_data.
  - sub_vld has priority: simultaneous wr_vld is fully suppressed, including on untargeted banks.
- Illegal sub_bank (≥ NUM_BANKS): no bank written, broadcast still suppressed, sub_err=1 in the next cycle only.
- Read-during-write, same bank and same address in the same cycle: rd_data returns the new write data (write-first bypass), per bank independently.
- Reset mid-operation: the pending rd_data_vld is dropped next cycle and counters return to 0. A write coinciding with reset is still performed, since the RAM is not reset-gated.
- No backpressure: the consumer must accept rd_data when rd_data_vld=1.

Decomposition:
- Shared package: typedef for the tap control bundle (rd_vld, rd_addr, inter, inter_first, wr_vld, wr_addr, sub_vld, sub_bank, sub_data) parametrised by ADDR_W/SEL_W/DATA_W; constant for the default bank count.
- Sub-module tap_bank_ram: one simple dual-port RAM, DATA_W × 2^ADDR_W, synchronous read, write-first bypass. Instantiated NUM_BANKS times via generate.
- Counters, address rotation, write decode and the valid pipeline stay in the top.

Test Plan:
1. Defaults; broadcast wr_vld at addr 3 with slice k = 0x100+k; then rd_vld at rd_addr 3 → next cycle rd_data_vld=1, slice k = 0x100+k.
2. Preload bank k word a = k*32+a. Pulse inter&inter_first, then 8 further inter pulses with rd_vld. Expected counters:
   - cnt_lo sequence 0,1,2,3,4,5,0,1,2;
   - cnt_hi = 6 after the 6th pulse.
   - Check the read at cnt_lo=2, cnt_hi=6: bank 0 addr 8 → 0x08, bank 5 addr 7 → 0xA7.
3. sub_vld bank 2 data 0xDEAD at addr 4, concurrent wr_vld data all-ones → only bank 2 addr 4 changes; other banks at addr 4 keep their prior values.
4. sub_vld with sub_bank=7 → no bank changes, sub_err=1 for exactly one cycle.
5. Same-cycle wr_vld addr 9 (slice k = 0x55+k) and rd_vld rd_addr 9 → rd_data slice k = 0x55+k.
6. Reset asserted the cycle after rd_vld → rd_data_vld=0, rd_data=0; next inter (without inter_first) uses cnt_lo=0, cnt_hi=0 → bank k reads addr k.

Source files
------------

// File: rtl/tap_bank_interleave_pkg.sv
// Shared definitions for the interleaved tap memory.
// tap_ctrl_t bundles one cycle of control at the default bank geometry.
package tap_bank_interleave_pkg;

  localparam int TAP_NUM_BANKS = 6;
  localparam int TAP_DATA_W    = 32;
  localparam int TAP_ADDR_W    = 5;
  localparam int TAP_SEL_W     = $clog2(TAP_NUM_BANKS);

  typedef struct packed {
    logic                  rd_vld;
    logic [TAP_ADDR_W-1:0] rd_addr;
    logic                  inter;
    logic                  inter_first;
    logic                  wr_vld;
    logic [TAP_ADDR_W-1:0] wr_addr;
    logic                  sub_vld;
    logic [TAP_SEL_W-1:0]  sub_bank;
    logic [TAP_DATA_W-1:0] sub_data;
  } tap_ctrl_t;

endpackage

// File: rtl/tap_bank_interleave_ram.sv
// One tap bank: simple dual-port RAM with registered read and write-first bypass.
// Only the read register is reset; stored words survive reset.
module tap_bank_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address write in the read cycle wins over the stored word.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/tap_bank_interleave.sv
// Multi-bank tap memory read as one wide word, with broadcast/sub writes
// and a rotating read-address mode for tap reuse.
module tap_bank_interleave
  import tap_bank_interleave_pkg::*;
#(
  parameter int NUM_BANKS = TAP_NUM_BANKS,
  parameter int DATA_W    = TAP_DATA_W,
  parameter int ADDR_W    = TAP_ADDR_W,
  parameter int SEL_W     = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_vld,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic                        inter,
  input  logic                        inter_first,
  input  logic                        wr_vld,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] wr_data,
  input  logic                        sub_vld,
  input  logic [SEL_W-1:0]            sub_bank,
  input  logic [DATA_W-1:0]           sub_data,
  output logic [NUM_BANKS*DATA_W-1:0] rd_data,
  output logic                        rd_data_vld,
  output logic                        sub_err
);

  localparam logic [SEL_W-1:0]  LO_LAST  = SEL_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0] HI_STEP  = ADDR_W'(NUM_BANKS);
  localparam logic [SEL_W:0]    LANE_MOD = (SEL_W+1)'(NUM_BANKS);

  logic [SEL_W-1:0]  cnt_lo;
  logic [ADDR_W-1:0] cnt_hi;
  logic              rotate;

  assign rotate = inter && !inter_first;

  // cnt_lo walks the bank lanes; each full lap advances the base by one bank group.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo <= '0;
      cnt_hi <= '0;
    end else if (inter) begin
      if (inter_first) begin
        cnt_lo <= '0;
        cnt_hi <= '0;
      end else if (cnt_lo == LO_LAST) begin
        cnt_lo <= '0;
        cnt_hi <= cnt_hi + HI_STEP;
      end else begin
        cnt_lo <= cnt_lo + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_vld <= 1'b0;
      sub_err     <= 1'b0;
    end else begin
      rd_data_vld <= rd_vld;
      sub_err     <= sub_vld && (int'(sub_bank) >= NUM_BANKS);
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic [SEL_W:0]    lane_sum;
    logic [ADDR_W-1:0] rot_addr;
    logic [ADDR_W-1:0] bank_addr;
    logic              bank_we;
    logic [DATA_W-1:0] bank_wdata;

    // cnt_lo + k stays below 2*NUM_BANKS, so one conditional subtract is the modulo.
    always_comb begin
      lane_sum = {1'b0, cnt_lo} + (SEL_W+1)'(k);
      if (lane_sum >= LANE_MOD) lane_sum = lane_sum - LANE_MOD;
    end

    assign rot_addr   = cnt_hi + ADDR_W'(lane_sum[SEL_W-1:0]);
    assign bank_addr  = rotate ? rot_addr : rd_addr;
    assign bank_we    = (sub_vld && (int'(sub_bank) == k)) || (wr_vld && !sub_vld);
    assign bank_wdata = sub_vld ? sub_data : wr_data[k*DATA_W +: DATA_W];

    tap_bank_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clk  (clk),
      .reset(reset),
      .we   (bank_we),
      .waddr(wr_addr),
      .wdata(bank_wdata),
      .re   (rd_vld),
      .raddr(bank_addr),
      .rdata(rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_tap_bank_interleave.sv
// Scoreboard bench for tap_bank_interleave: a behavioural memory/counter model
// predicts each read, expected words are queued at drive time and popped on rd_data_vld.
module tb_tap_bank_interleave;
  import tap_bank_interleave_pkg::*;

  localparam int NB = 6;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = 3;
  localparam int WW = NB * DW;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  tap_ctrl_t     ctrl;
  logic [WW-1:0] wr_data;
  logic [WW-1:0] rd_data;
  logic          rd_data_vld;
  logic          sub_err;

  tap_bank_interleave #(
    .NUM_BANKS(NB),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .SEL_W    (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_vld     (ctrl.rd_vld),
    .rd_addr    (ctrl.rd_addr),
    .inter      (ctrl.inter),
    .inter_first(ctrl.inter_first),
    .wr_vld     (ctrl.wr_vld),
    .wr_addr    (ctrl.wr_addr),
    .wr_data    (wr_data),
    .sub_vld    (ctrl.sub_vld),
    .sub_bank   (ctrl.sub_bank),
    .sub_data   (ctrl.sub_data),
    .rd_data    (rd_data),
    .rd_data_vld(rd_data_vld),
    .sub_err    (sub_err)
  );

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] mem_m [NB][DEPTH];
  int            lo_m = 0;
  int            hi_m = 0;
  logic [WW-1:0] hold_m = '0;
  logic [WW-1:0] exp_q [$];

  task automatic checkOutput(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: predict, drive, clock, then compare.
  task automatic applyStimulus(input tap_ctrl_t c, input logic [WW-1:0] wd, input logic rst);
    logic [WW-1:0] exp_rd;
    logic          vld_n;
    logic          err_n;
    bit            bank_we [NB];
    logic [DW-1:0] bank_wd [NB];
    int            a;
    exp_rd = '0;
    for (int k = 0; k < NB; k++) begin
      bank_we[k] = c.sub_vld ? (int'(c.sub_bank) == k) : c.wr_vld;
      bank_wd[k] = c.sub_vld ? c.sub_data : wd[k*DW +: DW];
    end
    for (int k = 0; k < NB; k++) begin
      if (c.inter && !c.inter_first) a = (((lo_m + k) % NB) + hi_m) % DEPTH;
      else a = int'(c.rd_addr);
      exp_rd[k*DW +: DW] = (bank_we[k] && int'(c.wr_addr) == a) ? bank_wd[k] : mem_m[k][a];
    end
    for (int k = 0; k < NB; k++)
      if (bank_we[k]) mem_m[k][c.wr_addr] = bank_wd[k];
    if (rst) begin
      lo_m = 0;
      hi_m = 0;
    end else if (c.inter) begin
      if (c.inter_first) begin
        lo_m = 0;
        hi_m = 0;
      end else if (lo_m == NB - 1) begin
        lo_m = 0;
        hi_m = (hi_m + NB) % DEPTH;
      end else begin
        lo_m = lo_m + 1;
      end
    end
    vld_n = !rst && c.rd_vld;
    err_n = !rst && c.sub_vld && (int'(c.sub_bank) >= NB);
    if (vld_n) exp_q.push_back(exp_rd);
    ctrl    = c;
    wr_data = wd;
    reset   = rst;
    @(posedge clk);
    #1;
    checkOutput("rd_data_vld", WW'(rd_data_vld), WW'(vld_n));
    checkOutput("sub_err", WW'(sub_err), WW'(err_n));
    if (rst) hold_m = '0;
    if (rd_data_vld && exp_q.size() > 0) begin
      hold_m = exp_q.pop_front();
      checkOutput("rd_data", rd_data, hold_m);
    end else begin
      if (vld_n && exp_q.size() > 0) hold_m = exp_q.pop_front();
      if (!vld_n) checkOutput("rd_hold", rd_data, hold_m);
    end
  endtask

  initial begin
    tap_ctrl_t     c;
    logic [WW-1:0] wd;
    c = '0;
    wd = '0;
    ctrl = '0;
    wr_data = '0;
    reset = 1'b1;

    applyStimulus(c, wd, 1'b1);
    applyStimulus(c, wd, 1'b1);
    applyStimulus(c, wd, 1'b0);

    $display("[TB] broadcast write and linear read");
    c = '0; c.wr_vld = 1'b1; c.wr_addr = 5'd3;
    for (int k = 0; k < NB; k++) wd[k*DW +: DW] = DW'(32'h100 + k);
    applyStimulus(c, wd, 1'b0);
    c = '0; c.rd_vld = 1'b1; c.rd_addr = 5'd3;
    applyStimulus(c, '0, 1'b0);
    checkOutput("bcast_bank5", WW'(rd_data[5*DW +: DW]), WW'(32'h105));

    $display("[TB] preload and interleaved reads");
    for (int a = 0; a < DEPTH; a++) begin
      c = '0; c.wr_vld = 1'b1; c.wr_addr = AW'(a);
      for (int k = 0; k < NB; k++) wd[k*DW +: DW] = DW'(k * 32 + a);
      applyStimulus(c, wd, 1'b0);
    end
    c = '0; c.inter = 1'b1; c.inter_first = 1'b1;
    applyStimulus(c, '0, 1'b0);
    for (int p = 0; p < 9; p++) begin
      c = '0; c.inter = 1'b1; c.rd_vld = 1'b1; c.rd_addr = AW'(p);
      applyStimulus(c, '0, 1'b0);
    end
    checkOutput("rot_bank0", WW'(rd_data[0 +: DW]), WW'(32'h08));
    checkOutput("rot_bank5", WW'(rd_data[5*DW +: DW]), WW'(32'hA7));

    $display("[TB] sub-write overrides broadcast");
    c = '0; c.sub_vld = 1'b1; c.sub_bank = 3'd2; c.sub_data = 32'hDEAD;
    c.wr_vld = 1'b1; c.wr_addr = 5'd4;
    applyStimulus(c, '1, 1'b0);
    c = '0; c.rd_vld = 1'b1; c.rd_addr = 5'd4;
    applyStimulus(c, '0, 1'b0);
    checkOutput("sub_bank2", WW'(rd_data[2*DW +: DW]), WW'(32'hDEAD));
    checkOutput("sub_bank0", WW'(rd_data[0 +: DW]), WW'(32'h04));

    $display("[TB] illegal sub bank");
    c = '0; c.sub_vld = 1'b1; c.sub_bank = 3'd7; c.sub_data = 32'hBEEF;
    c.wr_vld = 1'b1; c.wr_addr = 5'd4;
    applyStimulus(c, '1, 1'b0);
    c = '0;
    applyStimulus(c, '0, 1'b0);
    c = '0; c.rd_vld = 1'b1; c.rd_addr = 5'd4;
    applyStimulus(c, '0, 1'b0);

    $display("[TB] read-during-write bypass");
    c = '0; c.wr_vld = 1'b1; c.wr_addr = 5'd9; c.rd_vld = 1'b1; c.rd_addr = 5'd9;
    for (int k = 0; k < NB; k++) wd[k*DW +: DW] = DW'(32'h55 + k);
    applyStimulus(c, wd, 1'b0);
    checkOutput("bypass_bank3", WW'(rd_data[3*DW +: DW]), WW'(32'h58));

    $display("[TB] reset mid-operation");
    c = '0; c.rd_vld = 1'b1; c.rd_addr = 5'd10;
    applyStimulus(c, '0, 1'b0);
    c = '0;
    applyStimulus(c, '0, 1'b1);
    checkOutput("rst_rd_data", rd_data, '0);
    c = '0; c.inter = 1'b1; c.rd_vld = 1'b1;
    applyStimulus(c, '0, 1'b0);
    checkOutput("post_rst_bank1", WW'(rd_data[1*DW +: DW]), WW'(32'h21));
    c = '0;
    applyStimulus(c, '0, 1'b0);
    applyStimulus(c, '0, 1'b0);

    checkOutput("sb_empty", WW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
